vga_timing_generator: RTL and testbench
=======================================

# vga_timing_generator

Parametrised VGA raster timing generator, successor to the fixed-mode sync generator. It produces hsync/vsync with selectable polarity, an active-video flag, raster coordinates and a down-scaled framebuffer pixel index, all advanced by a pixel-clock enable so it can run from the system clock. It sits between the clock-enable divider and the framebuffer read port / VGA output pins.

## Interface
- H_TOTAL, 800, total columns per line
- V_TOTAL, 524, total rows per frame
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- H_FRONT_PORCH, 16, columns between active end and hsync start
- V_FRONT_PORCH, 11, rows between active end and vsync start
- H_BACK_PORCH, 48, columns between hsync end and line end
- V_BACK_PORCH, 31, rows between vsync end and frame end
- HSYNC_ACTIVE_LOW, 1, 1 = hsync pulses low, 0 = pulses high
- VSYNC_ACTIVE_LOW, 1, same for vsync
- SCALE, 2, framebuffer down-scale factor (1, 2 or 4)
- clk_i  input  1  system clock, all logic on rising edge
- reset_i  input  1  asynchronous, active-high reset
- pix_en_i  input  1  pixel-clock enable; raster advances only on edges where 1
- hsync_o  output  1  horizontal sync, polarity per HSYNC_ACTIVE_LOW
- vsync_o  output  1  vertical sync, polarity per VSYNC_ACTIVE_LOW
- video_en_o  output  1  1 while position is inside active area
- x_o  output  $clog2(H_ACTIVE)  active column, 0 outside active area
- y_o  output  $clog2(V_ACTIVE)  active row, 0 outside active area
- pixel_o  output  $clog2((H_ACTIVE/SCALE)*(V_ACTIVE/SCALE))  framebuffer address, 0 outside active area
- frame_start_o  output  1  one-clock pulse on entry to position (0,0)
- line_start_o  output  1  one-clock pulse on entry to h=0 of every row

## Operation
- Internal position (h,v): h in 0..H_TOTAL-1, v in 0..V_TOTAL-1. On pix_en_i=1: h increments; at h=H_TOTAL-1 wraps to 0 and v increments; at (H_TOTAL-1,V_TOTAL-1) wraps to (0,0).
- Region order per axis: active, front porch, sync, back porch. Sync widths: HSYNC_W = H_TOTAL-H_ACTIVE-H_FRONT_PORCH-H_BACK_PORCH (default 96); VSYNC_W likewise (default 2).
- hsync asserted for H_ACTIVE+H_FRONT_PORCH <= h < H_ACTIVE+H_FRONT_PORCH+HSYNC_W (default 656..751); vsync for rows 491..492 by default, over whole rows.
- video_en_o = (h < H_ACTIVE) && (v < V_ACTIVE); then x_o=h, y_o=v.
- pixel_o = (y/SCALE)*(H_ACTIVE/SCALE) + x/SCALE; produced with counters/adders only (no multiplier): line-base register advances by H_ACTIVE/SCALE after every SCALE-th active row, column term advances every SCALE-th active column.
- Elaboration errors if HSYNC_W<1, VSYNC_W<1, or H_ACTIVE/V_ACTIVE not divisible by SCALE.

## Timing
- Every output is a register; outputs change only on edges with pix_en_i=1 and describe the position entered on that edge. No combinational path from pix_en_i to outputs.
- pix_en_i=0: all outputs hold; frame_start_o/line_start_o drop to 0 after one clock (pulses last exactly one clk_i cycle even if pix_en_i stays high).
- Reset (async assert, any time incl. mid-line): position = (H_TOTAL-1, V_TOTAL-1); hsync_o/vsync_o inactive level; video_en_o=0; x_o=y_o=pixel_o=0; frame_start_o=line_start_o=0; pixel line-base cleared.
- First pix_en_i edge after reset deassert enters (0,0): frame_start_o=1, line_start_o=1, video_en_o=1, x_o=y_o=pixel_o=0.
- Frame period = H_TOTAL*V_TOTAL enabled cycles (default 419200).

## Test plan
- Reset then pix_en_i held 1: hsync_o=vsync_o=1, video_en_o=0 during reset; first edge -> frame_start_o=1, x_o=0, y_o=0, pixel_o=0.
- Defaults, pix_en_i=1: hsync_o low exactly for h=656..751 (96 cycles) of each line; vsync_o low exactly rows 491..492; frame_start_o period 419200 cycles.
- SCALE=2 addresses: (x=2,y=1)->1, (x=0,y=2)->320... i.e. 320 columns per row: (0,2)->320, (639,479)->76799; x_o/y_o/pixel_o=0 at h=640.
- pix_en_i asserted 1-in-4 clocks: outputs change only on enabled edges; line_start_o width 1 clk; frame period 1676800 clocks.
- reset_i pulsed at h=300,v=100: outputs return to reset values immediately (async); next enabled edge restarts at (0,0) with frame_start_o=1.
- HSYNC_ACTIVE_LOW=0, VSYNC_ACTIVE_LOW=0, SCALE=4: syncs pulse high at same positions; (639,479)->pixel_o=19199.

Source files
------------

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator: registered syncs, active-video flag, raster coordinates and
// down-scaled framebuffer address, all advanced by a pixel-clock enable.
module vga_timing_generator #(
    parameter int unsigned H_TOTAL          = 800,
    parameter int unsigned V_TOTAL          = 524,
    parameter int unsigned H_ACTIVE         = 640,
    parameter int unsigned V_ACTIVE         = 480,
    parameter int unsigned H_FRONT_PORCH    = 16,
    parameter int unsigned V_FRONT_PORCH    = 11,
    parameter int unsigned H_BACK_PORCH     = 48,
    parameter int unsigned V_BACK_PORCH     = 31,
    parameter int unsigned HSYNC_ACTIVE_LOW = 1,
    parameter int unsigned VSYNC_ACTIVE_LOW = 1,
    parameter int unsigned SCALE            = 2
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_i,
    input  logic                                                 pix_en_i,
    output logic                                                 hsync_o,
    output logic                                                 vsync_o,
    output logic                                                 video_en_o,
    output logic [$clog2(H_ACTIVE)-1:0]                          x_o,
    output logic [$clog2(V_ACTIVE)-1:0]                          y_o,
    output logic [$clog2((H_ACTIVE/SCALE)*(V_ACTIVE/SCALE))-1:0] pixel_o,
    output logic                                                 frame_start_o,
    output logic                                                 line_start_o
);

    localparam int HSYNC_W = int'(H_TOTAL) - int'(H_ACTIVE) - int'(H_FRONT_PORCH)
                             - int'(H_BACK_PORCH);
    localparam int VSYNC_W = int'(V_TOTAL) - int'(V_ACTIVE) - int'(V_FRONT_PORCH)
                             - int'(V_BACK_PORCH);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);
    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = $clog2(V_ACTIVE);
    localparam int unsigned PW = $clog2((H_ACTIVE/SCALE)*(V_ACTIVE/SCALE));
    localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam int unsigned HS_FIRST = H_ACTIVE + H_FRONT_PORCH;
    localparam int unsigned HS_LAST  = H_TOTAL - H_BACK_PORCH - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FRONT_PORCH;
    localparam int unsigned VS_LAST  = V_TOTAL - V_BACK_PORCH - 1;
    localparam int unsigned ROW_PIX  = H_ACTIVE / SCALE;

    localparam logic HS_IDLE = (HSYNC_ACTIVE_LOW != 0);
    localparam logic VS_IDLE = (VSYNC_ACTIVE_LOW != 0);

    if (HSYNC_W < 1) begin : g_bad_hsync
        $error("vga_timing_generator: horizontal sync width must be at least 1");
    end
    if (VSYNC_W < 1) begin : g_bad_vsync
        $error("vga_timing_generator: vertical sync width must be at least 1");
    end
    if ((H_ACTIVE % SCALE) != 0 || (V_ACTIVE % SCALE) != 0) begin : g_bad_scale
        $error("vga_timing_generator: active area must be divisible by SCALE");
    end

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [SW-1:0] xsub_q, xsub_d, ysub_q, ysub_d;
    logic [PW-1:0] col_q, col_d, base_q, base_d;

    logic          hsync_d, vsync_d, video_d, frame_d, line_d, active;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic [PW-1:0] pixel_d;

    // Position and the incremental address terms for the position entered on this edge.
    // base/col are frozen at the last active row/column so they never exceed the address range.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        xsub_d = xsub_q;
        ysub_d = ysub_q;
        col_d  = col_q;
        base_d = base_q;
        if (pix_en_i) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d    = '0;
                xsub_d = '0;
                col_d  = '0;
                if (v_q == VW'(V_TOTAL - 1)) begin
                    v_d    = '0;
                    ysub_d = '0;
                    base_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                    if (ysub_q == SW'(SCALE - 1)) begin
                        ysub_d = '0;
                        if (v_q < VW'(V_ACTIVE - 1)) begin
                            base_d = base_q + PW'(ROW_PIX);
                        end
                    end else begin
                        ysub_d = ysub_q + 1'b1;
                    end
                end
            end else begin
                h_d = h_q + 1'b1;
                if (xsub_q == SW'(SCALE - 1)) begin
                    xsub_d = '0;
                    if (h_q < HW'(H_ACTIVE - 1)) begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    xsub_d = xsub_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        active  = (h_d < HW'(H_ACTIVE)) && (v_d < VW'(V_ACTIVE));
        hsync_d = hsync_o;
        vsync_d = vsync_o;
        video_d = video_en_o;
        x_d     = x_o;
        y_d     = y_o;
        pixel_d = pixel_o;
        frame_d = 1'b0;
        line_d  = 1'b0;
        if (pix_en_i) begin
            hsync_d = ((h_d >= HW'(HS_FIRST)) && (h_d <= HW'(HS_LAST))) ^ HS_IDLE;
            vsync_d = ((v_d >= VW'(VS_FIRST)) && (v_d <= VW'(VS_LAST))) ^ VS_IDLE;
            video_d = active;
            x_d     = active ? h_d[XW-1:0] : '0;
            y_d     = active ? v_d[YW-1:0] : '0;
            pixel_d = active ? (base_d + col_d) : '0;
            frame_d = (h_d == '0) && (v_d == '0);
            line_d  = (h_d == '0);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_q           <= HW'(H_TOTAL - 1);
            v_q           <= VW'(V_TOTAL - 1);
            xsub_q        <= '0;
            ysub_q        <= '0;
            col_q         <= '0;
            base_q        <= '0;
            hsync_o       <= HS_IDLE;
            vsync_o       <= VS_IDLE;
            video_en_o    <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            pixel_o       <= '0;
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            xsub_q        <= xsub_d;
            ysub_q        <= ysub_d;
            col_q         <= col_d;
            base_q        <= base_d;
            hsync_o       <= hsync_d;
            vsync_o       <= vsync_d;
            video_en_o    <= video_d;
            x_o           <= x_d;
            y_o           <= y_d;
            pixel_o       <= pixel_d;
            frame_start_o <= frame_d;
            line_start_o  <= line_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default 640x480 instance plus a tiny 20x14 instance (SCALE=4, active-high syncs).
module tb_vga_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Default-parameter instance
    logic        rst0 = 1'b0, en0 = 1'b0;
    logic        hs0, vs0, vid0, fs0, ls0;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [16:0] pix0;

    vga_timing_generator dut0 (
        .clk_i(clk), .reset_i(rst0), .pix_en_i(en0), .hsync_o(hs0), .vsync_o(vs0),
        .video_en_o(vid0), .x_o(x0), .y_o(y0), .pixel_o(pix0), .frame_start_o(fs0),
        .line_start_o(ls0)
    );

    // Small instance: hsync h=10..15, vsync rows 10..11, 2x2 framebuffer
    logic       rst1 = 1'b0, en1 = 1'b0;
    logic       hs1, vs1, vid1, fs1, ls1;
    logic [2:0] x1, y1;
    logic [1:0] pix1;

    vga_timing_generator #(
        .H_TOTAL(20), .V_TOTAL(14), .H_ACTIVE(8), .V_ACTIVE(8), .H_FRONT_PORCH(2),
        .V_FRONT_PORCH(2), .H_BACK_PORCH(4), .V_BACK_PORCH(2), .HSYNC_ACTIVE_LOW(0),
        .VSYNC_ACTIVE_LOW(0), .SCALE(4)
    ) dut1 (
        .clk_i(clk), .reset_i(rst1), .pix_en_i(en1), .hsync_o(hs1), .vsync_o(vs1),
        .video_en_o(vid1), .x_o(x1), .y_o(y1), .pixel_o(pix1), .frame_start_o(fs1),
        .line_start_o(ls1)
    );

    int mh, mv, mh1, mv1;

    task automatic tick0();
        @(posedge clk);
        #1;
        if (en0) begin
            if (mh == 799) begin
                mh = 0;
                mv = (mv == 523) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    endtask

    task automatic goto0(input int th, input int tv);
        while (!(mh == th && mv == tv)) tick0();
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
        if (en1) begin
            if (mh1 == 19) begin
                mh1 = 0;
                mv1 = (mv1 == 13) ? 0 : mv1 + 1;
            end else begin
                mh1++;
            end
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; en0 = 1'b1; mh = 799; mv = 523;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (hs0 !== 1'b1) begin miscompares++; $display("FAIL reset_hsync: got %b want 1", hs0); end
        vectors++; if (vs0 !== 1'b1) begin miscompares++; $display("FAIL reset_vsync: got %b want 1", vs0); end
        vectors++; if (vid0 !== 1'b0) begin miscompares++; $display("FAIL reset_video: got %b want 0", vid0); end
        vectors++; if ({x0, y0, pix0} !== '0) begin miscompares++; $display("FAIL reset_coords: got x=%0d y=%0d p=%0d want 0", x0, y0, pix0); end
        vectors++; if ({fs0, ls0} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b%b want 00", fs0, ls0); end
        rst0 = 1'b0;
        tick0();
        vectors++; if ({fs0, ls0, vid0} !== 3'b111) begin miscompares++; $display("FAIL first_edge_flags: got fs=%b ls=%b vid=%b want 111", fs0, ls0, vid0); end
        vectors++; if ({x0, y0, pix0} !== '0) begin miscompares++; $display("FAIL first_edge_coords: got x=%0d y=%0d p=%0d want 0", x0, y0, pix0); end
        tick0();
        vectors++; if ({fs0, ls0} !== 2'b00) begin miscompares++; $display("FAIL pulse_width: got fs=%b ls=%b want 00", fs0, ls0); end
        vectors++; if (x0 !== 10'd1) begin miscompares++; $display("FAIL second_x: got %0d want 1", x0); end
    endtask

    task automatic test_hsync_line();
        int low_cnt = 0, first_low = -1, last_low = -1;
        for (int i = 0; i < 799; i++) begin
            tick0();
            if (hs0 === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = mh;
                last_low = mh;
            end
        end
        vectors++; if (low_cnt != 96) begin miscompares++; $display("FAIL hsync_width: got %0d want 96", low_cnt); end
        vectors++; if (first_low != 656) begin miscompares++; $display("FAIL hsync_first: got %0d want 656", first_low); end
        vectors++; if (last_low != 751) begin miscompares++; $display("FAIL hsync_last: got %0d want 751", last_low); end
        vectors++; if ({ls0, hs0, vs0} !== 3'b111) begin miscompares++; $display("FAIL line1_start: got ls=%b hs=%b vs=%b want 111", ls0, hs0, vs0); end
        vectors++; if (y0 !== 9'd1 || x0 !== 10'd0) begin miscompares++; $display("FAIL line1_coords: got x=%0d y=%0d want 0,1", x0, y0); end
    endtask

    task automatic test_addresses();
        goto0(2, 1);
        vectors++; if (pix0 !== 17'd1) begin miscompares++; $display("FAIL addr_2_1: got %0d want 1", pix0); end
        goto0(640, 1);
        vectors++; if ({vid0, x0, y0, pix0} !== '0) begin miscompares++; $display("FAIL blank_h640: got vid=%b x=%0d y=%0d p=%0d want 0", vid0, x0, y0, pix0); end
        goto0(0, 2);
        vectors++; if (pix0 !== 17'd320) begin miscompares++; $display("FAIL addr_0_2: got %0d want 320", pix0); end
        goto0(639, 3);
        vectors++; if (pix0 !== 17'd639) begin miscompares++; $display("FAIL addr_639_3: got %0d want 639", pix0); end
        goto0(639, 4);
        vectors++; if (pix0 !== 17'd959) begin miscompares++; $display("FAIL addr_639_4: got %0d want 959", pix0); end
    endtask

    task automatic test_pix_en_gating();
        int ex, ey;
        goto0(796, 4);
        for (int i = 0; i < 24; i++) begin
            en0 = (i % 4 == 0);
            tick0();
            ex = (mh < 640 && mv < 480) ? mh : 0;
            ey = (mh < 640 && mv < 480) ? mv : 0;
            vectors++; if (x0 !== 10'(ex)) begin miscompares++; $display("FAIL gate_x clk%0d: got %0d want %0d", i, x0, ex); end
            vectors++; if (y0 !== 9'(ey)) begin miscompares++; $display("FAIL gate_y clk%0d: got %0d want %0d", i, y0, ey); end
            vectors++; if (ls0 !== (en0 && mh == 0)) begin miscompares++; $display("FAIL gate_ls clk%0d: got %b want %b", i, ls0, en0 && mh == 0); end
        end
        en0 = 1'b1;
    endtask

    task automatic test_reset_midline();
        goto0(300, 5);
        vectors++; if (x0 !== 10'd300) begin miscompares++; $display("FAIL pre_reset_x: got %0d want 300", x0); end
        #1 rst0 = 1'b1;
        #1;
        vectors++; if ({x0, y0, pix0} !== '0) begin miscompares++; $display("FAIL async_reset_coords: got x=%0d y=%0d p=%0d want 0", x0, y0, pix0); end
        vectors++; if ({vid0, hs0, vs0} !== 3'b011) begin miscompares++; $display("FAIL async_reset_flags: got vid=%b hs=%b vs=%b want 011", vid0, hs0, vs0); end
        @(posedge clk);
        #1 rst0 = 1'b0;
        mh = 799; mv = 523;
        tick0();
        vectors++; if ({fs0, ls0, vid0} !== 3'b111 || x0 !== 10'd0 || y0 !== 9'd0) begin miscompares++; $display("FAIL restart: got fs=%b ls=%b vid=%b x=%0d y=%0d want 111,0,0", fs0, ls0, vid0, x0, y0); end
    endtask

    task automatic test_small_frame();
        int hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, pix_err = 0, vs_first = -1, vs_last = -1;
        int hs_first = -1, hs_last = -1, pix77 = -1, ep;
        rst1 = 1'b1; en1 = 1'b1; mh1 = 19; mv1 = 13;
        @(posedge clk);
        #1;
        vectors++; if ({hs1, vs1, vid1} !== 3'b000) begin miscompares++; $display("FAIL small_reset: got hs=%b vs=%b vid=%b want 000", hs1, vs1, vid1); end
        rst1 = 1'b0;
        for (int i = 0; i < 280; i++) begin
            tick1();
            if (hs1 === 1'b1) begin
                hs_cnt++;
                if (mv1 == 0 && hs_first < 0) hs_first = mh1;
                if (mv1 == 0) hs_last = mh1;
            end
            if (vs1 === 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = mv1;
                vs_last = mv1;
            end
            if (fs1 === 1'b1) fs_cnt++;
            ep = (mh1 < 8 && mv1 < 8) ? (mv1 / 4) * 2 + mh1 / 4 : 0;
            if (pix1 !== 2'(ep)) pix_err++;
            if (mh1 == 7 && mv1 == 7) pix77 = int'(pix1);
        end
        vectors++; if (hs_cnt != 84) begin miscompares++; $display("FAIL small_hsync_cycles: got %0d want 84", hs_cnt); end
        vectors++; if (hs_first != 10 || hs_last != 15) begin miscompares++; $display("FAIL small_hsync_span: got %0d..%0d want 10..15", hs_first, hs_last); end
        vectors++; if (vs_cnt != 40) begin miscompares++; $display("FAIL small_vsync_cycles: got %0d want 40", vs_cnt); end
        vectors++; if (vs_first != 10 || vs_last != 11) begin miscompares++; $display("FAIL small_vsync_rows: got %0d..%0d want 10..11", vs_first, vs_last); end
        vectors++; if (fs_cnt != 1) begin miscompares++; $display("FAIL small_frame_pulses: got %0d want 1", fs_cnt); end
        vectors++; if (pix_err != 0) begin miscompares++; $display("FAIL small_pixel_sweep: got %0d bad positions want 0", pix_err); end
        vectors++; if (pix77 != 3) begin miscompares++; $display("FAIL small_addr_7_7: got %0d want 3", pix77); end
        tick1();
        vectors++; if ({fs1, ls1} !== 2'b11) begin miscompares++; $display("FAIL small_wrap: got fs=%b ls=%b want 11", fs1, ls1); end
    endtask

    task automatic test_small_quarter_rate();
        int p1 = -1, p2 = -1, pulses = 0, hold_err = 0;
        logic [11:0] prev;
        for (int c = 0; c < 2400; c++) begin
            prev = {hs1, vs1, vid1, x1, y1, pix1};
            en1 = (c % 4 == 0);
            tick1();
            if (!en1 && ({hs1, vs1, vid1, x1, y1, pix1} !== prev || fs1 !== 1'b0 || ls1 !== 1'b0))
                hold_err++;
            if (fs1 === 1'b1) begin
                pulses++;
                if (p1 < 0) p1 = c; else if (p2 < 0) p2 = c;
            end
        end
        en1 = 1'b1;
        vectors++; if (hold_err != 0) begin miscompares++; $display("FAIL quarter_hold: got %0d changes on disabled edges want 0", hold_err); end
        vectors++; if (pulses != 2) begin miscompares++; $display("FAIL quarter_pulses: got %0d want 2", pulses); end
        vectors++; if (p1 != 1116) begin miscompares++; $display("FAIL quarter_first_pulse: got clk %0d want 1116", p1); end
        vectors++; if (p2 - p1 != 1120) begin miscompares++; $display("FAIL quarter_period: got %0d want 1120", p2 - p1); end
    endtask

    initial begin
        test_reset();
        test_hsync_line();
        test_addresses();
        test_pix_en_gating();
        test_reset_midline();
        test_small_frame();
        test_small_quarter_rate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
